// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: load-use stalls, taken-branch
// flushes, a multi-cycle mult/div busy window and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
    parameter int unsigned MULDIV_LAT = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_muldiv,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             muldiv_busy,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned CntW = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(MULDIV_LAT - 1);
    localparam bit MulDivMultiCycle = (MULDIV_LAT > 1);

    typedef enum logic [0:0] {
        StIdle,
        StBusy
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              load_use;

    // Register 0 is hard-wired, so a load targeting it can never create a hazard.
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        muldiv_busy = 1'b0;
        muldiv_done = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ex_branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (id_muldiv && MulDivMultiCycle) begin
                        state_d = StBusy;
                        cnt_d   = CntLoad;
                    end
                end
                StBusy: begin
                    // EX is occupied by the mult/div; branch and load-use are ignored here.
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    muldiv_busy = 1'b1;
                    cnt_d       = cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        muldiv_done = 1'b1;
                        state_d     = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (!pc_write && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;

`ifndef SYNTHESIS
    busy_stalls_pc: assert property (@(posedge clk) muldiv_busy |-> !pc_write);
    done_only_when_busy: assert property (@(posedge clk) muldiv_done |-> muldiv_busy);
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomized and directed bench for hazard_stall_ctrl against a cycle-level behavioural model.
module tb_hazard_stall_ctrl;

    localparam int unsigned Lat    = 4;
    localparam int          MaxCnt = 65535;
    localparam int          MaxSat = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, id_muldiv, ex_mem_read, ex_branch_taken;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done;
    logic [15:0] stall_cycles;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_busy, s_done;
    logic [3:0]  s_stall_cycles;
    logic [5:0]  dut_o;

    int checks = 0;
    int errors = 0;
    int m_busy_left = 0;
    int m_cnt = 0;
    int m_cnt_sat = 0;

    always #5 clk = ~clk;

    assign dut_o = {pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done};

    hazard_stall_ctrl #(.MULDIV_LAT(Lat), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .muldiv_busy(muldiv_busy),
        .muldiv_done(muldiv_done), .stall_cycles(stall_cycles)
    );

    hazard_stall_ctrl #(.MULDIV_LAT(Lat), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_muldiv(id_muldiv), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
        .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .muldiv_busy(s_busy),
        .muldiv_done(s_done), .stall_cycles(s_stall_cycles)
    );

    function automatic logic model_lu();
        return ex_mem_read && (ex_rd != 0) &&
               ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    endfunction

    // {pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done}
    function automatic logic [5:0] model_out();
        if (rst)                  return 6'b001100;
        if (m_busy_left > 0)      return {5'b00011, m_busy_left == 1};
        if (ex_branch_taken)      return 6'b111100;
        if (model_lu())           return 6'b000100;
        return 6'b110000;
    endfunction

    // Advance one clock and the model with it; returns at the following falling edge.
    task automatic tick();
        logic [5:0] o;
        logic       lu;
        o  = model_out();
        lu = model_lu();
        @(posedge clk);
        if (rst) begin
            m_busy_left = 0;
            m_cnt       = 0;
            m_cnt_sat   = 0;
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            else if (!ex_branch_taken && !lu && id_muldiv && Lat > 1) m_busy_left = Lat - 1;
            if (!o[5]) begin
                if (m_cnt < MaxCnt) m_cnt++;
                if (m_cnt_sat < MaxSat) m_cnt_sat++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rt = 1'b0; id_muldiv = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        repeat (2) begin
            tick();
            #1;
            checks++;
            if (dut_o !== 6'b001100) begin
                errors++; $display("FAIL reset_ctrl: got %b expected %b", dut_o, 6'b001100);
            end
            checks++;
            if (stall_cycles !== 16'd0) begin
                errors++; $display("FAIL reset_stall: got %0d expected 0", stall_cycles);
            end
        end
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL reset_release: got %b expected %b", dut_o, 6'b110000);
        end
        tick();
    endtask

    task automatic test_load_use();
        int base;
        base = m_cnt;
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        #1;
        checks++;
        if (dut_o !== 6'b000100) begin
            errors++; $display("FAIL lu_rs: got %b expected %b", dut_o, 6'b000100);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cycles !== 16'(base + 1)) begin
            errors++; $display("FAIL lu_count: got %0d expected %0d", stall_cycles, base + 1);
        end
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL lu_r0: got %b expected %b", dut_o, 6'b110000);
        end
        tick();
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL lu_rt_unused: got %b expected %b", dut_o, 6'b110000);
        end
        tick();
        id_uses_rt = 1'b1;
        #1;
        checks++;
        if (dut_o !== 6'b000100) begin
            errors++; $display("FAIL lu_rt_used: got %b expected %b", dut_o, 6'b000100);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cycles !== 16'(base + 2)) begin
            errors++; $display("FAIL lu_total: got %0d expected %0d", stall_cycles, base + 2);
        end
    endtask

    task automatic test_branch_flush();
        int base;
        base = m_cnt;
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        id_muldiv = 1'b1;
        #1;
        checks++;
        if (dut_o !== 6'b111100) begin
            errors++; $display("FAIL branch_ctrl: got %b expected %b", dut_o, 6'b111100);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL branch_no_muldiv: got %b expected %b", dut_o, 6'b110000);
        end
        checks++;
        if (stall_cycles !== 16'(base)) begin
            errors++; $display("FAIL branch_count: got %0d expected %0d", stall_cycles, base);
        end
    endtask

    task automatic test_muldiv();
        int base;
        base = m_cnt;
        idle_inputs();
        id_muldiv = 1'b1;
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL md_issue: got %b expected %b", dut_o, 6'b110000);
        end
        tick();
        id_muldiv = 1'b0;
        // Hazards presented during BUSY must have no effect.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dut_o !== {5'b00011, i == 2}) begin
                errors++; $display("FAIL md_busy%0d: got %b expected %b", i, dut_o,
                                   {5'b00011, i == 2});
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL md_after: got %b expected %b", dut_o, 6'b110000);
        end
        checks++;
        if (stall_cycles !== 16'(base + 3)) begin
            errors++; $display("FAIL md_count: got %0d expected %0d", stall_cycles, base + 3);
        end
    endtask

    task automatic test_back_to_back();
        int base, nbusy, ndone;
        base = m_cnt; nbusy = 0; ndone = 0;
        idle_inputs();
        id_muldiv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (dut_o !== model_out()) begin
                errors++; $display("FAIL b2b_cycle%0d: got %b expected %b", i, dut_o, model_out());
            end
            nbusy += int'(muldiv_busy);
            ndone += int'(muldiv_done);
            tick();
        end
        id_muldiv = 1'b0;
        #1;
        checks++;
        if (nbusy !== 6 || ndone !== 2) begin
            errors++; $display("FAIL b2b_busy: got busy=%0d done=%0d expected busy=6 done=2",
                               nbusy, ndone);
        end
        checks++;
        if (stall_cycles !== 16'(base + 6)) begin
            errors++; $display("FAIL b2b_count: got %0d expected %0d", stall_cycles, base + 6);
        end
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        id_muldiv = 1'b1;
        tick();
        id_muldiv = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (dut_o !== 6'b001100) begin
            errors++; $display("FAIL rmb_in_reset: got %b expected %b", dut_o, 6'b001100);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (dut_o !== 6'b110000) begin
            errors++; $display("FAIL rmb_after: got %b expected %b", dut_o, 6'b110000);
        end
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++; $display("FAIL rmb_count: got %0d expected 0", stall_cycles);
        end
        tick();
        #1;
        checks++;
        if (muldiv_done !== 1'b0 || muldiv_busy !== 1'b0) begin
            errors++; $display("FAIL rmb_no_done: got busy=%b done=%b expected 0 0",
                               muldiv_busy, muldiv_done);
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
        for (int i = 1; i <= 20; i++) begin
            tick();
            #1;
            checks++;
            if (s_stall_cycles !== 4'((i > 15) ? 15 : i)) begin
                errors++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, s_stall_cycles,
                                   (i > 15) ? 15 : i);
            end
            checks++;
            if (stall_cycles !== 16'(i)) begin
                errors++; $display("FAIL sat_wide%0d: got %0d expected %0d", i, stall_cycles, i);
            end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_uses_rt      = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_muldiv       = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (dut_o !== model_out()) begin
                errors++; $display("FAIL rand_ctrl%0d: got %b expected %b", i, dut_o, model_out());
            end
            checks++;
            if (stall_cycles !== 16'(m_cnt) || s_stall_cycles !== 4'(m_cnt_sat)) begin
                errors++; $display("FAIL rand_cnt%0d: got %0d/%0d expected %0d/%0d", i,
                                   stall_cycles, s_stall_cycles, m_cnt, m_cnt_sat);
            end
            tick();
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_branch_flush();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_busy();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
